// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one decryption round per clock.
// Round keys are fetched combinationally through the key_idx/round_key port.

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign y = INV_SBOX[a];
endmodule

module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t       state, state_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [127:0] st, st_nxt;
  logic [127:0] isr, isb, ark, imc;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // k selects which of x, 2x, 4x, 8x are summed, so k is the GF(2^8) constant itself
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return ({8{k[0]}} & x) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  // Row r rotates right by r: output column c takes its row-r byte from column c-r
  always_comb begin
    isr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        isr[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (.a(isr[127-8*i -: 8]), .y(isb[127-8*i -: 8]));
  end

  assign ark = isb ^ round_key;

  always_comb begin
    imc = '0;
    for (int c = 0; c < 4; c++)
      imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rnd   <= '0;
      st    <= '0;
    end else begin
      state <= state_nxt;
      rnd   <= rnd_nxt;
      st    <= st_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd;
    st_nxt    = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    key_idx   = 4'(NR);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_nxt    = in_data ^ round_key;
          rnd_nxt   = 4'(NR - 1);
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        key_idx = rnd;
        st_nxt  = imc;
        if (rnd == 4'd1) state_nxt = FINAL;
        else             rnd_nxt   = rnd - 4'd1;
      end
      FINAL: begin
        key_idx   = 4'd0;
        st_nxt    = ark;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_data = st;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using the FIPS-197 C.1 AES-128 vector
// and its expanded key schedule served through a combinational key store.

module tb_aes_inv_cipher_iter;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  int nchecks = 0;
  int nfail   = 0;
  int cycle   = 0;
  int acceptCycle = 0;
  int firstAccept = 0;

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .key_idx(key_idx), .round_key(round_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Expanded key schedule for key 000102030405060708090a0b0c0d0e0f
  function automatic logic [127:0] keyStore(input logic [3:0] i);
    case (i)
      4'd0:  return 128'h000102030405060708090a0b0c0d0e0f;
      4'd1:  return 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      4'd2:  return 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      4'd3:  return 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      4'd4:  return 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      4'd5:  return 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      4'd6:  return 128'h5e390f7df7a69296a7553dc10aa31f6b;
      4'd7:  return 128'h14f9701ae35fe28c440adf4d4ea9c026;
      4'd8:  return 128'h47438735a41c65b9e016baf4aebf7ad2;
      4'd9:  return 128'h549932d1f08557681093ed9cbe2c974e;
      4'd10: return 128'h13111d7fe3944a17f307a78b4d2b30c5;
      default: return 128'h0;
    endcase
  endfunction

  assign round_key = keyStore(key_idx);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer a block, wait (bounded) for acceptance, and record the accept cycle
  task automatic applyStimulus(input logic [127:0] ct);
    int guard = 0;
    in_data  = ct;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    checkOutput("accept_ready", 128'(in_ready), 128'(1));
    checkOutput("accept_keyidx", 128'(key_idx), 128'(10));
    checkOutput("accept_rk10", round_key, RK10);
    tick();
    in_valid    = 1'b0;
    acceptCycle = cycle;
  endtask

  // Follow the key index down to 0, then check latency and plaintext
  task automatic waitResult(input logic [127:0] pt);
    int guard = 0;
    while (!out_valid && guard < 30) begin
      if (guard < 10) checkOutput("key_seq", 128'(key_idx), 128'(9 - guard));
      tick();
      guard++;
    end
    checkOutput("out_valid", 128'(out_valid), 128'(1));
    checkOutput("latency", 128'(cycle - acceptCycle), 128'(10));
    checkOutput("plaintext", out_data, pt);
  endtask

  task automatic pulseReady();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("ret_idle_valid", 128'(out_valid), 128'(0));
    checkOutput("ret_idle_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_out_data", out_data, 128'h0);
    checkOutput("rst_key_idx", 128'(key_idx), 128'(10));

    $display("[TB] C.1 vector, key sequencing and backpressure");
    applyStimulus(CT);
    waitResult(PT);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput("bp_valid", 128'(out_valid), 128'(1));
      checkOutput("bp_data", out_data, PT);
      checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
    end
    pulseReady();

    $display("[TB] busy drop");
    applyStimulus(CT);
    in_valid = 1'b1;
    in_data  = 128'hdeadbeef0123456789abcdeffedcba98;
    checkOutput("busy_in_ready", 128'(in_ready), 128'(0));
    waitResult(PT);
    checkOutput("busy_done_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    pulseReady();
    applyStimulus(CT);
    waitResult(PT);
    pulseReady();

    $display("[TB] reset mid-round");
    applyStimulus(CT);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("mid_key_idx", 128'(key_idx), 128'(5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_ready", 128'(in_ready), 128'(1));
    checkOutput("mid_rst_valid", 128'(out_valid), 128'(0));
    checkOutput("mid_rst_data", out_data, 128'h0);
    rst = 1'b1; in_valid = 1'b1; in_data = CT;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("rst_wins_ready", 128'(in_ready), 128'(1));
    checkOutput("rst_wins_key", 128'(key_idx), 128'(10));
    applyStimulus(CT);
    waitResult(PT);
    pulseReady();

    $display("[TB] back-to-back");
    out_ready = 1'b1;
    applyStimulus(CT);
    firstAccept = acceptCycle;
    waitResult(PT);
    applyStimulus(CT);
    checkOutput("b2b_spacing", 128'(acceptCycle - firstAccept), 128'(12));
    waitResult(PT);
    tick();
    checkOutput("b2b_idle", 128'(in_ready), 128'(1));
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end
endmodule
